// File: rtl/spi_slave_regbank.sv
// SPI mode-0 responder exposing a bank of R/W control registers and read-only
// status bytes. All SPI pins are oversampled in the sys_clk domain.
//
// Ports:
//   sys_clk, sys_rst_n   : system clock, async active-low reset
//   SPI_SCLK/CSN/MOSI    : SPI inputs from the PS master (asynchronous)
//   SPI_MISO             : slave-out data, 0 outside the read data phase
//   reg_out              : R/W registers, register n at [8n+7:8n]
//   stat_in              : status bytes, same packing, snapshotted on read
//   wr_stb               : one-cycle pulse per committed write
//   wr_addr, wr_data     : address/data of the last committed write
//   frame_err            : one-cycle pulse on aborted or malformed frame
//   busy                 : synchronized CSN is low
module spi_slave_regbank #(
    parameter int unsigned REG_NUM = 4,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 SPI_SCLK,
    input  logic                 SPI_CSN,
    input  logic                 SPI_MOSI,
    output logic                 SPI_MISO,
    output logic [REG_NUM*8-1:0] reg_out,
    input  logic [REG_NUM*8-1:0] stat_in,
    output logic                 wr_stb,
    output logic [6:0]           wr_addr,
    output logic [7:0]           wr_data,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int unsigned   AW         = 7;
    localparam int unsigned   DW         = 8;
    localparam int unsigned   CW         = 5;
    localparam int unsigned   FRAME_BITS = 16;
    localparam logic [CW-1:0] CNT_ADDR   = CW'(7);   // next rise completes R/W + address
    localparam logic [CW-1:0] CNT_DATA   = CW'(8);
    localparam logic [CW-1:0] CNT_FULL   = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_MAX    = CW'(17);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

    logic                 r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic                 r_csn_s1, r_csn_s2, r_csn_d;
    logic                 r_mosi_s1, r_mosi_s2, r_mosi_d;
    logic                 r_sclk_rise, r_sclk_fall, r_csn_fall, r_csn_rise;
    logic [1:0]           r_sync_age;
    logic                 r_csn_armed;
    logic                 r_busy;

    state_t               r_state;
    logic [FRAME_BITS-1:0] r_rx_sr;
    logic [DW-1:0]        r_tx_sr;
    logic [CW-1:0]        r_bit_cnt;
    logic                 r_is_rd;
    logic                 r_miso;
    logic [REG_NUM*8-1:0] r_reg_out;
    logic                 r_wr_stb;
    logic [AW-1:0]        r_wr_addr;
    logic [DW-1:0]        r_wr_data;
    logic                 r_frame_err;

    logic [AW-1:0]        w_rd_addr;
    logic [DW-1:0]        w_rd_byte;

    // Synchronizers, edge-detect stage and registered edge strobes.
    // The CSN chain resets high and csn_fall is only accepted once the real
    // pin has been seen high, so a frame already in progress at reset
    // release is ignored until the next genuine falling edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sclk_s1   <= 1'b0;
            r_sclk_s2   <= 1'b0;
            r_sclk_d    <= 1'b0;
            r_csn_s1    <= 1'b1;
            r_csn_s2    <= 1'b1;
            r_csn_d     <= 1'b1;
            r_mosi_s1   <= 1'b0;
            r_mosi_s2   <= 1'b0;
            r_mosi_d    <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_sclk_fall <= 1'b0;
            r_csn_fall  <= 1'b0;
            r_csn_rise  <= 1'b0;
            r_sync_age  <= 2'd0;
            r_csn_armed <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sclk_s1   <= SPI_SCLK;
            r_sclk_s2   <= r_sclk_s1;
            r_sclk_d    <= r_sclk_s2;
            r_csn_s1    <= SPI_CSN;
            r_csn_s2    <= r_csn_s1;
            r_csn_d     <= r_csn_s2;
            r_mosi_s1   <= SPI_MOSI;
            r_mosi_s2   <= r_mosi_s1;
            r_mosi_d    <= r_mosi_s2;
            r_sclk_rise <= r_sclk_s2 & ~r_sclk_d;
            r_sclk_fall <= ~r_sclk_s2 & r_sclk_d;
            r_csn_fall  <= ~r_csn_s2 & r_csn_d & r_csn_armed;
            r_csn_rise  <= r_csn_s2 & ~r_csn_d;
            if (r_sync_age != 2'd2) r_sync_age <= r_sync_age + 2'd1;
            if (r_sync_age == 2'd2 && r_csn_s2) r_csn_armed <= 1'b1;
            r_busy      <= ~r_csn_s2;
        end
    end

    // Read byte for the address completed by the current rising edge.
    assign w_rd_addr = {r_rx_sr[5:0], r_mosi_d};

    always_comb begin
        w_rd_byte = '0;
        for (int i = 0; i < int'(REG_NUM); i++) begin
            if (w_rd_addr == AW'(i))
                w_rd_byte = r_reg_out[i*8 +: 8];
            if (w_rd_addr == AW'(i + int'(REG_NUM)))
                w_rd_byte = stat_in[i*8 +: 8];
        end
    end

    // Frame FSM: shift, read-byte load/serialize, commit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_bit_cnt   <= '0;
            r_is_rd     <= 1'b0;
            r_miso      <= 1'b0;
            r_reg_out   <= {REG_NUM{RST_VAL}};
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_stb    <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= '0;
                    r_miso    <= 1'b0;
                    if (r_csn_fall) begin
                        r_rx_sr <= '0;
                        r_tx_sr <= '0;
                        r_is_rd <= 1'b0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_csn_rise) begin
                        r_state <= ST_COMMIT;
                    end else begin
                        if (r_sclk_rise) begin
                            r_rx_sr <= {r_rx_sr[FRAME_BITS-2:0], r_mosi_d};
                            if (r_bit_cnt != CNT_MAX) r_bit_cnt <= r_bit_cnt + CW'(1);
                            // r_rx_sr[6] holds the R/W bit just before the 8th rise
                            if (r_bit_cnt == CNT_ADDR && r_rx_sr[6]) begin
                                r_is_rd <= 1'b1;
                                r_tx_sr <= w_rd_byte;
                            end
                        end
                        if (r_sclk_fall && r_is_rd) begin
                            if (r_bit_cnt >= CNT_DATA && r_bit_cnt < CNT_FULL) begin
                                r_miso  <= r_tx_sr[DW-1];
                                r_tx_sr <= {r_tx_sr[DW-2:0], 1'b0};
                            end else begin
                                r_miso  <= 1'b0;
                            end
                        end
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                    r_miso  <= 1'b0;
                    if (r_bit_cnt != CNT_FULL) begin
                        r_frame_err <= 1'b1;
                    end else if (!r_rx_sr[15]) begin
                        r_wr_stb  <= 1'b1;
                        r_wr_addr <= r_rx_sr[14:8];
                        r_wr_data <= r_rx_sr[7:0];
                        for (int i = 0; i < int'(REG_NUM); i++) begin
                            if (r_rx_sr[14:8] == AW'(i))
                                r_reg_out[i*8 +: 8] <= r_rx_sr[7:0];
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign SPI_MISO  = r_miso;
    assign reg_out   = r_reg_out;
    assign wr_stb    = r_wr_stb;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Testbench for spi_slave_regbank: directed scenarios followed by random
// reads/writes at SCLK = sys_clk/10, checked against a register-map model.
module tb_spi_slave_regbank;
    localparam int unsigned REG_NUM = 4;
    localparam logic [7:0]  RST_VAL = 8'h3C;
    localparam int          HALF    = 5;

    logic                 sys_clk   = 1'b0;
    logic                 sys_rst_n = 1'b0;
    logic                 SPI_SCLK  = 1'b0;
    logic                 SPI_CSN   = 1'b1;
    logic                 SPI_MOSI  = 1'b0;
    logic                 SPI_MISO;
    logic [REG_NUM*8-1:0] reg_out;
    logic [REG_NUM*8-1:0] stat_in   = '0;
    logic                 wr_stb;
    logic [6:0]           wr_addr;
    logic [7:0]           wr_data;
    logic                 frame_err;
    logic                 busy;

    int checks   = 0;
    int failures = 0;
    int n_wr     = 0;
    int n_err    = 0;

    logic [7:0] m_reg  [REG_NUM];
    logic [7:0] m_stat [REG_NUM];

    spi_slave_regbank #(.REG_NUM(REG_NUM), .RST_VAL(RST_VAL)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .SPI_SCLK  (SPI_SCLK),
        .SPI_CSN   (SPI_CSN),
        .SPI_MOSI  (SPI_MOSI),
        .SPI_MISO  (SPI_MISO),
        .reg_out   (reg_out),
        .stat_in   (stat_in),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Pulse counters: one count per cycle the strobe is high.
    always @(negedge sys_clk) begin
        if (wr_stb === 1'b1)    n_wr++;
        if (frame_err === 1'b1) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input int a);
        if (a < int'(REG_NUM))       return m_reg[a];
        if (a < 2 * int'(REG_NUM))   return m_stat[a - int'(REG_NUM)];
        return 8'h00;
    endfunction

    function automatic logic [REG_NUM*8-1:0] m_regout();
        logic [REG_NUM*8-1:0] v;
        for (int i = 0; i < int'(REG_NUM); i++) v[i*8 +: 8] = m_reg[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < int'(REG_NUM); i++) m_reg[i] = RST_VAL;
    endtask

    task automatic set_stat(input int idx, input logic [7:0] val);
        m_stat[idx] = val;
        stat_in[idx*8 +: 8] = val;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".reg_out"},   32'(reg_out), 32'({REG_NUM{RST_VAL}}));
        check({tag, ".miso"},      32'(SPI_MISO), 32'd0);
        check({tag, ".wr_stb"},    32'(wr_stb), 32'd0);
        check({tag, ".frame_err"}, 32'(frame_err), 32'd0);
        check({tag, ".busy"},      32'(busy), 32'd0);
        check({tag, ".wr_addr"},   32'(wr_addr), 32'd0);
        check({tag, ".wr_data"},   32'(wr_data), 32'd0);
    endtask

    // One SCLK period, entered with SCLK low. Returns MISO one cycle before
    // the rising edge and just before it.
    task automatic send_bit(input logic b, output logic s_early, output logic s_late);
        SPI_MOSI = b;
        repeat (HALF - 1) @(negedge sys_clk);
        s_early = SPI_MISO;
        @(negedge sys_clk);
        s_late = SPI_MISO;
        SPI_SCLK = 1'b1;
        repeat (HALF) @(negedge sys_clk);
        SPI_SCLK = 1'b0;
    endtask

    // Full CSN window of n bits, MSB (bits[n-1]) first; smp[i] is MISO seen
    // before the rise that shifts bits[i].
    task automatic xfer(input logic [16:0] bits, input int n,
                        output logic [16:0] smp, output logic stab);
        logic e, l;
        smp  = '0;
        stab = 1'b1;
        @(negedge sys_clk);
        SPI_CSN = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(bits[i], e, l);
            smp[i] = l;
            if (e !== l) stab = 1'b0;
        end
        repeat (HALF) @(negedge sys_clk);
        SPI_CSN  = 1'b1;
        SPI_MOSI = 1'b0;
        repeat (12) @(negedge sys_clk);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d, input string tag);
        logic [16:0] smp;
        logic        stab;
        int          w0, e0;
        w0 = n_wr;
        e0 = n_err;
        xfer({2'b00, a, d}, 16, smp, stab);
        if (int'(a) < int'(REG_NUM)) m_reg[a] = d;
        check({tag, ".wr_stb_cnt"}, 32'(n_wr - w0), 32'd1);
        check({tag, ".err_cnt"},    32'(n_err - e0), 32'd0);
        check({tag, ".reg_out"},    32'(reg_out), 32'(m_regout()));
        check({tag, ".miso_zero"},  32'(smp[15:0]), 32'd0);
        if (int'(a) < int'(REG_NUM)) begin
            check({tag, ".wr_addr"}, 32'(wr_addr), 32'(a));
            check({tag, ".wr_data"}, 32'(wr_data), 32'(d));
        end
    endtask

    task automatic do_read(input logic [6:0] a, input string tag);
        logic [16:0] smp;
        logic        stab;
        int          w0, e0;
        w0 = n_wr;
        e0 = n_err;
        xfer({2'b01, a, 8'h00}, 16, smp, stab);
        check({tag, ".data"},      32'(smp[7:0]), 32'(m_read(int'(a))));
        check({tag, ".addr_zero"}, 32'(smp[15:8]), 32'd0);
        check({tag, ".stable"},    32'(stab), 32'd1);
        check({tag, ".no_pulse"},  32'((n_wr - w0) + (n_err - e0)), 32'd0);
        check({tag, ".reg_out"},   32'(reg_out), 32'(m_regout()));
    endtask

    initial begin
        logic [16:0] smp;
        logic        stab, e, l;
        logic [15:0] fr;
        int          w0, e0, r;
        logic [6:0]  a;

        m_reset();
        for (int i = 0; i < int'(REG_NUM); i++) set_stat(i, 8'h00);

        // Reset values
        repeat (3) @(negedge sys_clk);
        check_reset("reset");
        sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);

        // Write/readback
        do_write(7'd1, 8'h5A, "wr1");
        check("wr1.byte1", 32'(reg_out[15:8]), 32'h5A);
        do_read(7'd1, "rd1");

        // Status read and unmapped read
        set_stat(2, 8'hC3);
        do_read(7'd6, "rd_stat6");
        do_read(7'h7F, "rd_7f");

        // Aborted frame: first 10 bits of write 0x02FF
        w0 = n_wr; e0 = n_err;
        fr = 16'h02FF;
        xfer(17'(fr >> 6), 10, smp, stab);
        check("short.err_cnt", 32'(n_err - e0), 32'd1);
        check("short.wr_cnt",  32'(n_wr - w0), 32'd0);
        check("short.reg_out", 32'(reg_out), 32'(m_regout()));

        // Overlong frame: 17 bits
        w0 = n_wr; e0 = n_err;
        xfer({16'h0133, 1'b1}, 17, smp, stab);
        check("long.err_cnt", 32'(n_err - e0), 32'd1);
        check("long.wr_cnt",  32'(n_wr - w0), 32'd0);
        check("long.reg_out", 32'(reg_out), 32'(m_regout()));

        // Write to a read-only address
        set_stat(0, 8'h96);
        do_write(7'd4, 8'h11, "wr_ro4");
        do_read(7'd4, "rd_ro4");

        // Reset in the middle of a write frame
        do_write(7'd2, 8'hA7, "pre_rst");
        fr = {1'b0, 7'd0, 8'hEE};
        @(negedge sys_clk);
        SPI_CSN = 1'b0;
        for (int i = 15; i >= 11; i--) send_bit(fr[i], e, l);
        check("midrst.busy", 32'(busy), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check_reset("midrst");
        m_reset();
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        w0 = n_wr; e0 = n_err;
        for (int i = 10; i >= 0; i--) send_bit(fr[i], e, l);
        repeat (HALF) @(negedge sys_clk);
        SPI_CSN = 1'b1;
        repeat (12) @(negedge sys_clk);
        check("midrst.no_pulse", 32'((n_wr - w0) + (n_err - e0)), 32'd0);
        check("midrst.reg_out",  32'(reg_out), 32'(m_regout()));
        do_write(7'd0, 8'hEE, "post_rst_wr");
        do_read(7'd0, "post_rst_rd");

        // Random traffic at the minimum clock ratio
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < int'(REG_NUM); i++) set_stat(i, 8'($urandom));
            r = int'($urandom_range(0, 9));
            if (r < 8) a = 7'(r);
            else       a = 7'($urandom_range(8, 127));
            if ($urandom_range(0, 1) == 0) do_write(a, 8'($urandom), "rnd_wr");
            else                           do_read(a, "rnd_rd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_regbank.md
# spi_slave_regbank

PL-side SPI responder for the PS SPI0 master. It sits on a spare PS chip-select next to the optical power meter, temperature sensor and APD ADC slaves, and exposes a small bank of 8-bit control registers and read-only status bytes to PS software. It runs entirely in the `sys_clk` domain and oversamples `SPI_SCLK`, `SPI_CSN` and `SPI_MOSI`. It supports SPI mode 0, MSB first.

## Interface
Parameters:
- `REG_NUM`, default 4: number of R/W registers and of status bytes. Legal range 1..64.
- `RST_VAL`, default 8'h00: reset value of every R/W register.

Ports:
- `sys_clk` input, 1 bit: system clock. Must be ≥ 10× the SCLK frequency.
- `sys_rst_n` input, 1 bit: reset, asynchronous, active-low.
- `SPI_SCLK` input, 1 bit: SPI clock from PS, asynchronous.
- `SPI_CSN` input, 1 bit: chip select, active-low, asynchronous.
- `SPI_MOSI` input, 1 bit: master-out data.
- `SPI_MISO` output, 1 bit: slave-out data. Driven 0 whenever no read data phase is active.
- `reg_out` output, REG_NUM*8 bits: R/W registers, flat. Register n occupies [8n+7:8n].
- `stat_in` input, REG_NUM*8 bits: status bytes, same packing as `reg_out`. Sampled when a read is captured.
- `wr_stb` output, 1 bit: one-cycle pulse on each committed write.
- `wr_addr` output, 7 bits: address of the last committed write.
- `wr_data` output, 8 bits: data of the last committed write.
- `frame_err` output, 1 bit: one-cycle pulse when a frame is aborted or malformed.
- `busy` output, 1 bit: high while CSN is seen low (synchronized).

## Operation
**Input synchronization and edge detection**
- Each of SCLK, CSN and MOSI passes through a 2-FF synchronizer.
- One further register provides edge detection, giving sclk_rise, sclk_fall, csn_fall and csn_rise.

**Frame format:** 16 bits.
- bit15 = R/W. 1 is a read.
- bits14:8 = address, 7 bits.
- bits7:0 = data. The write payload comes from MOSI; the read payload is returned on MISO.

**Address map**
- 0..REG_NUM-1: R/W registers.
- REG_NUM..2*REG_NUM-1: `stat_in` bytes, read-only. Writes to these addresses are discarded silently.
- All other addresses read 8'h00 and ignore writes.

**State machine**
- IDLE:
  - `bit_cnt`=0, MISO=0.
  - On csn_fall: clear the shift register and `bit_cnt`, then go to SHIFT.
- SHIFT:
  - On each sclk_rise: shift in the synchronized MOSI, `bit_cnt`++ (5 bits, saturating at 17).
  - When `bit_cnt` goes 7→8 with bit15 = 1: load the read byte for the address into `tx_sr`.
  - On sclk_fall with `bit_cnt` ≥ 8 and the frame a read:
    - MISO ← `tx_sr[7]`, then `tx_sr` shifts left.
    - After the 16th fall, MISO = 0.
  - MISO stays 0 during the address phase and for write frames.
  - On csn_rise: go to COMMIT.
- COMMIT, one cycle, then IDLE:
  - If `bit_cnt` = 16 and the frame is a write to a RW address: update the register, pulse `wr_stb`, and latch `wr_addr`/`wr_data`.
  - If `bit_cnt` = 16 and the frame is a write to any other address: pulse `wr_stb` with no register change.
  - If `bit_cnt` ≠ 16 (short frame, long frame, or CSN released mid-frame): pulse `frame_err`, change nothing.
  - Reads with `bit_cnt` = 16: no pulse.

**Reset values**
- `reg_out` = {REG_NUM{RST_VAL}}.
- `SPI_MISO`, `wr_stb`, `frame_err`, `busy` = 0.
- `wr_addr` = 0, `wr_data` = 0.
- FSM = IDLE.

**Reset and boundary conditions**
- Reset mid-frame: everything returns to reset values. The rest of the in-progress frame is ignored until the next csn_fall.
- csn_fall and sclk_rise detected in the same cycle: the sclk_rise is ignored. Mode 0 forbids this combination.
- A read of address A followed by a write in the same CSN-low window is not possible, because a frame is exactly one transaction.

## Timing
- Edge detection latency: 3 sys_clk cycles from a pin transition to the internal edge strobe.
- MISO update: 4 cycles after the SCLK falling pin edge.
  - This requires the SCLK low half-period to be ≥ 5 sys_clk cycles, so MISO is stable before the next rising edge.
- `reg_out`, `wr_stb`, `wr_addr` and `wr_data` change in the cycle after COMMIT is entered. That is 5 cycles after the CSN rising pin edge.
- The read data snapshot of `stat_in` is taken on the cycle the 8th sclk_rise is detected.
- Back-to-back frames need CSN high for ≥ 4 sys_clk cycles.

## Test plan
- **Write/readback:** write 0x5A to addr 1 (frame 0x015A) → `wr_stb` ×1, `wr_addr`=1, `wr_data`=0x5A, `reg_out[15:8]`=0x5A. Then read addr 1 (frame 0x8100) → MISO bits 0x5A on rising edges 9..16.
- **Status read:** set `stat_in` byte 2 = 0xC3 with REG_NUM=4, read addr 6 → 0xC3. Read addr 0x7F → 0x00.
- **Aborted frame:** raise CSN after 10 bits of write 0x02FF → `frame_err` ×1, no `wr_stb`, `reg_out` unchanged. Overlong 17-bit frame → `frame_err` ×1, no write.
- **Read-only write:** write 0x11 to addr 4 → `wr_stb` pulses, `reg_out` unchanged, subsequent read of addr 4 returns `stat_in` byte 0.
- **Reset mid-frame:** assert `sys_rst_n` low after 5 bits → all outputs at reset values. Next full write frame is accepted normally.
- **Minimum-ratio clocking:** SCLK = sys_clk/10, random reads and writes → all readbacks correct, MISO stable ≥ 1 cycle before each rising SCLK.
